// File: rtl/mem_wb_stage_pkg.sv
// Shared types for the memory/writeback stage.
// Holds the MEMOP encodings, FSM states and the reset value of SP.
package mem_wb_stage_pkg;

    typedef enum logic [1:0] {
        MEMOP_ALU   = 2'd0,
        MEMOP_LOAD  = 2'd1,
        MEMOP_STORE = 2'd2,
        MEMOP_PUSH  = 2'd3
    } memop_e;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_MEM_WAIT = 1'b1
    } state_e;

    localparam logic [15:0] SP_INIT_DEF = 16'h00FF;

endpackage

// File: rtl/sp_reg.sv
// Architectural stack-pointer register.
// Ports: CLK, RESET (sync, high), i_ld load enable, i_d next value, o_q current SP.
module sp_reg #(
    parameter logic [15:0] RST_VAL = 16'h00FF
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        i_ld,
    input  logic [15:0] i_d,
    output logic [15:0] o_q
);

    logic [15:0] r_q;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_q <= RST_VAL;
        end else if (i_ld) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/mem_wb_stage.sv
// Memory-access / writeback stage: ALU writeback, load, store, push.
// Ports: VALID_IN/READY_OUT handshake, op inputs, MEM_* bus, WB_* strobe, SP, BRANCH_OUT, MEM_ERR.
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter logic [15:0] SP_INIT     = SP_INIT_DEF,
    parameter int          REG_ADDR_W  = 3,
    parameter int          MEM_TIMEOUT = 255
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  VALID_IN,
    output logic                  READY_OUT,
    input  logic [1:0]            MEMOP,
    input  logic [15:0]           ALU_OUT,
    input  logic [15:0]           SP_ADDR,
    input  logic [15:0]           STORE_DATA,
    input  logic                  REG_WE,
    input  logic [REG_ADDR_W-1:0] DEST,
    input  logic                  BRANCHING,
    output logic [15:0]           SP,
    output logic                  MEM_REQ,
    output logic                  MEM_WE,
    output logic [15:0]           MEM_ADDR,
    output logic [15:0]           MEM_WDATA,
    input  logic [15:0]           MEM_RDATA,
    input  logic                  MEM_ACK,
    output logic                  WB_EN,
    output logic [REG_ADDR_W-1:0] WB_ADDR,
    output logic [15:0]           WB_DATA,
    output logic                  BRANCH_OUT,
    output logic                  MEM_ERR
);

    // Abort fires on the edge where the counter would reach MEM_TIMEOUT.
    localparam logic [7:0] LP_TMO_LAST = 8'(MEM_TIMEOUT - 1);

    state_e                r_state;
    memop_e                r_op;
    logic [REG_ADDR_W-1:0] r_dest;
    logic                  r_reg_we;
    logic [7:0]            r_cnt;
    logic                  r_mem_req;
    logic                  r_mem_we;
    logic [15:0]           r_mem_addr;
    logic [15:0]           r_mem_wdata;
    logic                  r_wb_en;
    logic [REG_ADDR_W-1:0] r_wb_addr;
    logic [15:0]           r_wb_data;
    logic                  r_branch;
    logic                  r_mem_err;

    state_e w_next;
    memop_e w_op;
    logic   w_accept;
    logic   w_ack;
    logic   w_expire;
    logic   w_sp_ld;

    always_comb begin
        w_op     = memop_e'(MEMOP);
        w_accept = VALID_IN && (r_state == ST_IDLE);
        w_ack    = (r_state == ST_MEM_WAIT) && MEM_ACK;
        // Ack on the expiry edge wins over the timeout.
        w_expire = (r_state == ST_MEM_WAIT) && !MEM_ACK &&
                   (r_cnt == LP_TMO_LAST);
        w_sp_ld  = w_ack && (r_op == MEMOP_PUSH);
        w_next   = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && (w_op != MEMOP_ALU)) begin
                    w_next = ST_MEM_WAIT;
                end
            end
            ST_MEM_WAIT: begin
                if (w_ack || w_expire) begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state     <= ST_IDLE;
            r_op        <= MEMOP_ALU;
            r_dest      <= '0;
            r_reg_we    <= 1'b0;
            r_cnt       <= 8'd0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= 16'd0;
            r_mem_wdata <= 16'd0;
            r_wb_en     <= 1'b0;
            r_wb_addr   <= '0;
            r_wb_data   <= 16'd0;
            r_branch    <= 1'b0;
            r_mem_err   <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_wb_en   <= 1'b0;
            r_mem_err <= 1'b0;
            r_branch  <= w_accept && BRANCHING;
            if (w_accept) begin
                if (w_op == MEMOP_ALU) begin
                    r_wb_en   <= REG_WE;
                    r_wb_addr <= DEST;
                    r_wb_data <= ALU_OUT;
                end else begin
                    r_op       <= w_op;
                    r_dest     <= DEST;
                    // Only loads may write the register file.
                    r_reg_we   <= REG_WE && (w_op == MEMOP_LOAD);
                    r_cnt      <= 8'd0;
                    r_mem_req  <= 1'b1;
                    r_mem_we   <= (w_op != MEMOP_LOAD);
                    r_mem_addr <= (w_op == MEMOP_PUSH) ? SP_ADDR : ALU_OUT;
                    if (w_op != MEMOP_LOAD) begin
                        r_mem_wdata <= STORE_DATA;
                    end
                end
            end
            if (w_ack) begin
                r_mem_req <= 1'b0;
                r_cnt     <= 8'd0;
                if (r_op == MEMOP_LOAD) begin
                    r_wb_en   <= r_reg_we;
                    r_wb_addr <= r_dest;
                    r_wb_data <= MEM_RDATA;
                end
            end else if (w_expire) begin
                r_mem_req <= 1'b0;
                r_mem_err <= 1'b1;
                r_cnt     <= 8'd0;
            end else if (r_state == ST_MEM_WAIT) begin
                r_cnt <= r_cnt + 8'd1;
            end
        end
    end

    // SP takes the latched push address, which already wraps at 16 bits.
    sp_reg #(
        .RST_VAL (SP_INIT)
    ) u_sp_reg (
        .CLK   (CLK),
        .RESET (RESET),
        .i_ld  (w_sp_ld),
        .i_d   (r_mem_addr),
        .o_q   (SP)
    );

    assign READY_OUT  = (r_state == ST_IDLE);
    assign MEM_REQ    = r_mem_req;
    assign MEM_WE     = r_mem_we;
    assign MEM_ADDR   = r_mem_addr;
    assign MEM_WDATA  = r_mem_wdata;
    assign WB_EN      = r_wb_en;
    assign WB_ADDR    = r_wb_addr;
    assign WB_DATA    = r_wb_data;
    assign BRANCH_OUT = r_branch;
    assign MEM_ERR    = r_mem_err;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage with a writeback scoreboard.
// Expected WB writes are queued at stimulus time and popped on WB_EN.
module tb_mem_wb_stage;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        VALID_IN;
    logic        READY_OUT;
    logic [1:0]  MEMOP;
    logic [15:0] ALU_OUT;
    logic [15:0] SP_ADDR;
    logic [15:0] STORE_DATA;
    logic        REG_WE;
    logic [2:0]  DEST;
    logic        BRANCHING;
    logic [15:0] SP;
    logic        MEM_REQ;
    logic        MEM_WE;
    logic [15:0] MEM_ADDR;
    logic [15:0] MEM_WDATA;
    logic [15:0] MEM_RDATA;
    logic        MEM_ACK;
    logic        WB_EN;
    logic [2:0]  WB_ADDR;
    logic [15:0] WB_DATA;
    logic        BRANCH_OUT;
    logic        MEM_ERR;

    int total = 0;
    int bad   = 0;
    logic [18:0] wb_q[$];

    mem_wb_stage dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .VALID_IN   (VALID_IN),
        .READY_OUT  (READY_OUT),
        .MEMOP      (MEMOP),
        .ALU_OUT    (ALU_OUT),
        .SP_ADDR    (SP_ADDR),
        .STORE_DATA (STORE_DATA),
        .REG_WE     (REG_WE),
        .DEST       (DEST),
        .BRANCHING  (BRANCHING),
        .SP         (SP),
        .MEM_REQ    (MEM_REQ),
        .MEM_WE     (MEM_WE),
        .MEM_ADDR   (MEM_ADDR),
        .MEM_WDATA  (MEM_WDATA),
        .MEM_RDATA  (MEM_RDATA),
        .MEM_ACK    (MEM_ACK),
        .WB_EN      (WB_EN),
        .WB_ADDR    (WB_ADDR),
        .WB_DATA    (WB_DATA),
        .BRANCH_OUT (BRANCH_OUT),
        .MEM_ERR    (MEM_ERR)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every WB pulse must match the oldest expected write.
    always @(negedge CLK) begin
        if (WB_EN === 1'b1) begin
            if (wb_q.size() == 0) begin
                chk("wb_unexpected", {13'd0, WB_ADDR, WB_DATA}, 32'hFFFF_FFFF);
            end else begin
                chk("wb_entry", {13'd0, WB_ADDR, WB_DATA},
                    {13'd0, wb_q.pop_front()});
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic [1:0] op, input logic [15:0] alu,
                         input logic [15:0] spa, input logic [15:0] sd,
                         input logic we, input logic [2:0] dst);
        VALID_IN   = 1'b1;
        MEMOP      = op;
        ALU_OUT    = alu;
        SP_ADDR    = spa;
        STORE_DATA = sd;
        REG_WE     = we;
        DEST       = dst;
    endtask

    // Push acked on its first request cycle.
    task automatic do_push(input logic [15:0] spa, input logic [15:0] sd);
        drive(2'd3, 16'h0, spa, sd, 1'b1, 3'd1);
        tick();
        VALID_IN = 1'b0;
        chk("push_req", {31'd0, MEM_REQ}, 32'd1);
        chk("push_we", {31'd0, MEM_WE}, 32'd1);
        chk("push_addr", {16'd0, MEM_ADDR}, {16'd0, spa});
        chk("push_wdata", {16'd0, MEM_WDATA}, {16'd0, sd});
        MEM_ACK = 1'b1;
        tick();
        MEM_ACK = 1'b0;
        chk("push_sp", {16'd0, SP}, {16'd0, spa});
        chk("push_req_drop", {31'd0, MEM_REQ}, 32'd0);
        chk("push_no_wb", {31'd0, WB_EN}, 32'd0);
        chk("push_ready", {31'd0, READY_OUT}, 32'd1);
    endtask

    initial begin
        int reqc;
        RESET      = 1'b1;
        VALID_IN   = 1'b0;
        MEMOP      = 2'd0;
        ALU_OUT    = 16'h0;
        SP_ADDR    = 16'h0;
        STORE_DATA = 16'h0;
        REG_WE     = 1'b0;
        DEST       = 3'd0;
        BRANCHING  = 1'b0;
        MEM_RDATA  = 16'h0;
        MEM_ACK    = 1'b0;
        tick();
        tick();
        RESET = 1'b0;
        chk("rst_ready", {31'd0, READY_OUT}, 32'd1);
        chk("rst_sp", {16'd0, SP}, 32'h00FF);
        chk("rst_req", {31'd0, MEM_REQ}, 32'd0);
        chk("rst_wb_en", {31'd0, WB_EN}, 32'd0);
        chk("rst_branch", {31'd0, BRANCH_OUT}, 32'd0);
        chk("rst_err", {31'd0, MEM_ERR}, 32'd0);
        chk("rst_addr", {16'd0, MEM_ADDR}, 32'd0);
        chk("rst_wb_data", {16'd0, WB_DATA}, 32'd0);

        // Single ALU writeback.
        drive(2'd0, 16'h0030, 16'h0, 16'h0, 1'b1, 3'd2);
        wb_q.push_back({3'd2, 16'h0030});
        tick();
        VALID_IN = 1'b0;
        chk("alu_wb_en", {31'd0, WB_EN}, 32'd1);
        chk("alu_wb_addr", {29'd0, WB_ADDR}, 32'd2);
        chk("alu_wb_data", {16'd0, WB_DATA}, 32'h0030);
        chk("alu_ready", {31'd0, READY_OUT}, 32'd1);
        tick();
        chk("alu_pulse_end", {31'd0, WB_EN}, 32'd0);

        // Three back-to-back ALU ops give three consecutive pulses.
        for (int i = 0; i < 3; i++) begin
            drive(2'd0, 16'h0A00 + 16'(i), 16'h0, 16'h0, 1'b1, 3'(i + 4));
            wb_q.push_back({3'(i + 4), 16'h0A00 + 16'(i)});
            tick();
            chk("b2b_wb_en", {31'd0, WB_EN}, 32'd1);
            chk("b2b_ready", {31'd0, READY_OUT}, 32'd1);
        end
        VALID_IN = 1'b0;
        tick();
        chk("b2b_idle", {31'd0, WB_EN}, 32'd0);

        // Branch flag follows accepts only; REG_WE=0 gives no WB.
        drive(2'd0, 16'h1111, 16'h0, 16'h0, 1'b0, 3'd3);
        BRANCHING = 1'b1;
        tick();
        VALID_IN = 1'b0;
        chk("br_out", {31'd0, BRANCH_OUT}, 32'd1);
        chk("br_no_wb", {31'd0, WB_EN}, 32'd0);
        tick();
        chk("br_idle", {31'd0, BRANCH_OUT}, 32'd0);
        BRANCHING = 1'b0;

        // Load acked after three request cycles.
        drive(2'd1, 16'h0010, 16'h0, 16'h0, 1'b1, 3'd5);
        tick();
        VALID_IN = 1'b0;
        wb_q.push_back({3'd5, 16'hBEEF});
        for (int i = 0; i < 3; i++) begin
            chk("ld_req", {31'd0, MEM_REQ}, 32'd1);
            chk("ld_we", {31'd0, MEM_WE}, 32'd0);
            chk("ld_addr", {16'd0, MEM_ADDR}, 32'h0010);
            chk("ld_ready", {31'd0, READY_OUT}, 32'd0);
            chk("ld_no_wb", {31'd0, WB_EN}, 32'd0);
            if (i == 2) begin
                MEM_ACK   = 1'b1;
                MEM_RDATA = 16'hBEEF;
            end
            tick();
        end
        MEM_ACK   = 1'b0;
        MEM_RDATA = 16'h0;
        chk("ld_wb_en", {31'd0, WB_EN}, 32'd1);
        chk("ld_wb_data", {16'd0, WB_DATA}, 32'hBEEF);
        chk("ld_req_drop", {31'd0, MEM_REQ}, 32'd0);
        chk("ld_ready_back", {31'd0, READY_OUT}, 32'd1);
        tick();
        chk("ld_pulse_end", {31'd0, WB_EN}, 32'd0);

        // Pushes, including the 16-bit wrap to zero.
        do_push(16'h0100, 16'h005F);
        do_push(16'hFFFF, 16'h0001);
        do_push(16'h0000, 16'h0002);

        // Store that never gets acked: timeout after 255 request cycles.
        drive(2'd2, 16'h0020, 16'h0, 16'h1234, 1'b1, 3'd6);
        tick();
        VALID_IN = 1'b0;
        chk("st_we", {31'd0, MEM_WE}, 32'd1);
        chk("st_wdata", {16'd0, MEM_WDATA}, 32'h1234);
        reqc = 0;
        while (MEM_REQ === 1'b1 && reqc < 400) begin
            chk("st_err_early", {31'd0, MEM_ERR}, 32'd0);
            reqc++;
            tick();
        end
        chk("tmo_cycles", 32'(reqc), 32'd255);
        chk("tmo_err", {31'd0, MEM_ERR}, 32'd1);
        chk("tmo_req", {31'd0, MEM_REQ}, 32'd0);
        chk("tmo_sp", {16'd0, SP}, 32'h0000);
        chk("tmo_no_wb", {31'd0, WB_EN}, 32'd0);
        chk("tmo_ready", {31'd0, READY_OUT}, 32'd1);
        drive(2'd0, 16'h7777, 16'h0, 16'h0, 1'b1, 3'd7);
        wb_q.push_back({3'd7, 16'h7777});
        tick();
        VALID_IN = 1'b0;
        chk("tmo_err_pulse", {31'd0, MEM_ERR}, 32'd0);
        chk("tmo_next_wb", {31'd0, WB_EN}, 32'd1);

        // Reset in the middle of a push discards it.
        drive(2'd3, 16'h0, 16'h0200, 16'hAAAA, 1'b0, 3'd0);
        tick();
        VALID_IN = 1'b0;
        chk("rp_req", {31'd0, MEM_REQ}, 32'd1);
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        chk("rp_req_low", {31'd0, MEM_REQ}, 32'd0);
        chk("rp_sp", {16'd0, SP}, 32'h00FF);
        chk("rp_ready", {31'd0, READY_OUT}, 32'd1);
        MEM_ACK = 1'b1;
        tick();
        MEM_ACK = 1'b0;
        chk("late_ack_sp", {16'd0, SP}, 32'h00FF);
        chk("late_ack_req", {31'd0, MEM_REQ}, 32'd0);
        chk("late_ack_wb", {31'd0, WB_EN}, 32'd0);
        tick();
        chk("sb_drained", 32'(wb_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
